// File: rtl/mul_sequencer_if.sv
// Multiply engine request/result bundle between the main FSM and mul_sequencer.
//
// Handshake: the requester raises start for one cycle with a valid MulOp and
// stable SrcA/SrcB. The request is taken only while Busy is low and the engine
// is idle. Otherwise it is dropped and never queued. Busy stays high until the
// operation retires. Done is a one-cycle pulse. ResultLo/ResultHi/MulFlags are
// valid from that cycle on and hold their values until the next Done.
interface mul_sequencer_if #(
  parameter int WIDTH = 32
);
  logic             start;
  logic [2:0]       MulOp;
  logic [WIDTH-1:0] SrcA;
  logic [WIDTH-1:0] SrcB;
  logic             Busy;
  logic             Done;
  logic [WIDTH-1:0] ResultLo;
  logic [WIDTH-1:0] ResultHi;
  logic [1:0]       MulFlags;
  logic [1:0]       dbg_state;

  modport master (
    output start, MulOp, SrcA, SrcB,
    input  Busy, Done, ResultLo, ResultHi, MulFlags, dbg_state
  );

  modport slave (
    input  start, MulOp, SrcA, SrcB,
    output Busy, Done, ResultLo, ResultHi, MulFlags, dbg_state
  );
endinterface

// File: rtl/mul_sequencer.sv
// Radix-2 shift-add multiply engine for MUL / UMULL / SMULL.
// The engine handles one multiplier bit per cycle.
// SMULL runs on operand magnitudes, and the engine negates the product in SIGN.
// All outputs are registered.
module mul_sequencer #(
  parameter int WIDTH = 32
) (
  input logic            clk,
  input logic            reset,
  mul_sequencer_if.slave bus
);
  localparam int CW = $clog2(WIDTH + 1);
  localparam logic [2:0] OP_MUL   = 3'b101;
  localparam logic [2:0] OP_UMULL = 3'b110;
  localparam logic [2:0] OP_SMULL = 3'b111;

  typedef enum logic [1:0] {IDLE = 2'd0, RUN = 2'd1, SIGN = 2'd2, DONE = 2'd3} state_t;

  state_t             state;
  logic [CW-1:0]      cnt;
  logic [2*WIDTH-1:0] p;
  logic [WIDTH-1:0]   m;
  logic               neg;
  logic [2:0]         op;
  logic               busy_q;
  logic               done_q;
  logic [WIDTH-1:0]   res_lo;
  logic [WIDTH-1:0]   res_hi;
  logic [1:0]         flags_q;

  logic               op_valid;
  logic [WIDTH-1:0]   mag_a;
  logic [WIDTH-1:0]   mag_b;
  logic               neg_in;
  logic [WIDTH:0]     addend;
  logic [WIDTH:0]     sum;
  logic [2*WIDTH-1:0] p_fin;
  logic               n_fin;
  logic               z_fin;

  // Operand prep, one shift-add step, and the sign-corrected product with its flags.
  always_comb begin
    op_valid = (bus.MulOp == OP_MUL) || (bus.MulOp == OP_UMULL) || (bus.MulOp == OP_SMULL);
    mag_a    = bus.SrcA;
    mag_b    = bus.SrcB;
    neg_in   = 1'b0;
    if (bus.MulOp == OP_SMULL) begin
      // The most negative value maps to its own bit pattern.
      // Read as unsigned, that pattern is the correct magnitude.
      if (bus.SrcA[WIDTH-1]) mag_a = -bus.SrcA;
      if (bus.SrcB[WIDTH-1]) mag_b = -bus.SrcB;
      neg_in = bus.SrcA[WIDTH-1] ^ bus.SrcB[WIDTH-1];
    end
    addend = p[0] ? {1'b0, m} : '0;
    sum    = {1'b0, p[2*WIDTH-1:WIDTH]} + addend;
    p_fin  = neg ? -p : p;
    if (op == OP_MUL) begin
      n_fin = p_fin[WIDTH-1];
      z_fin = (p_fin[WIDTH-1:0] == '0);
    end else begin
      n_fin = p_fin[2*WIDTH-1];
      z_fin = (p_fin == '0);
    end
  end

  // Sequencer FSM with registered Busy/Done and result registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state   <= IDLE;
      cnt     <= '0;
      p       <= '0;
      m       <= '0;
      neg     <= 1'b0;
      op      <= 3'b000;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      res_lo  <= '0;
      res_hi  <= '0;
      flags_q <= 2'b00;
    end else begin
      case (state)
        IDLE: begin
          if (bus.start && op_valid) begin
            op     <= bus.MulOp;
            m      <= mag_a;
            p      <= {{WIDTH{1'b0}}, mag_b};
            neg    <= neg_in;
            cnt    <= '0;
            busy_q <= 1'b1;
            state  <= RUN;
          end
        end
        RUN: begin
          // Shift {carry, sum, low word} right one place.
          p   <= {sum, p[WIDTH-1:1]};
          cnt <= cnt + 1'b1;
          if (cnt == CW'(WIDTH - 1)) state <= SIGN;
        end
        SIGN: begin
          p       <= p_fin;
          res_lo  <= p_fin[WIDTH-1:0];
          res_hi  <= p_fin[2*WIDTH-1:WIDTH];
          flags_q <= {n_fin, z_fin};
          done_q  <= 1'b1;
          state   <= DONE;
        end
        DONE: begin
          done_q <= 1'b0;
          busy_q <= 1'b0;
          state  <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.Busy      = busy_q;
  assign bus.Done      = done_q;
  assign bus.ResultLo  = res_lo;
  assign bus.ResultHi  = res_hi;
  assign bus.MulFlags  = flags_q;
  assign bus.dbg_state = state;
endmodule

// File: tb/tb_mul_sequencer.sv
// Directed bench for mul_sequencer.
// A scoreboard queue holds the expected {hi, lo, flags}.
// A monitor pops one entry on every Done.
module tb_mul_sequencer;
  localparam int W = 32;
  localparam logic [2:0] OP_MUL   = 3'b101;
  localparam logic [2:0] OP_UMULL = 3'b110;
  localparam logic [2:0] OP_SMULL = 3'b111;

  logic clk;
  logic reset;
  int   checks;
  int   errors;

  logic [2*W+1:0] exp_q[$];

  mul_sequencer_if #(.WIDTH(W)) bus ();

  mul_sequencer #(.WIDTH(W)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  // Clock and reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Monitor: every Done must match the oldest expected result
  always @(negedge clk) begin
    if (bus.Done) begin
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL unexpected_done: got hi=%h lo=%h flags=%b, required no Done",
                 bus.ResultHi, bus.ResultLo, bus.MulFlags);
      end else begin
        logic [2*W+1:0] e;
        e = exp_q.pop_front();
        if ({bus.ResultHi, bus.ResultLo, bus.MulFlags} !== e) begin
          errors++;
          $display("FAIL result: got hi=%h lo=%h flags=%b, required hi=%h lo=%h flags=%b",
                   bus.ResultHi, bus.ResultLo, bus.MulFlags,
                   e[2*W+1:W+2], e[W+1:2], e[1:0]);
        end
      end
    end
  end

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] req);
    checks++;
    if (got !== req) begin
      errors++;
      $display("FAIL %s: got %h, required %h", name, got, req);
    end
  endtask

  // Driver: one-cycle start pulse (set at a negedge, cleared at the next)
  task automatic issue(input logic [2:0] op, input logic [W-1:0] a, input logic [W-1:0] b);
    @(negedge clk);
    bus.start = 1'b1;
    bus.MulOp = op;
    bus.SrcA  = a;
    bus.SrcB  = b;
    @(negedge clk);
    bus.start = 1'b0;
  endtask

  // Full operation: pushes the expectation, checks Busy every cycle and the Done cycle (34)
  task automatic run_op(input string name, input logic [2:0] op, input logic [W-1:0] a,
                        input logic [W-1:0] b, input logic [W-1:0] hi, input logic [W-1:0] lo,
                        input logic [1:0] fl);
    int k;
    int busy_bad;
    exp_q.push_back({hi, lo, fl});
    issue(op, a, b);
    k = 1;
    busy_bad = 0;
    while (!bus.Done && k < 60) begin
      if (bus.Busy !== 1'b1) busy_bad++;
      @(negedge clk);
      k++;
    end
    if (bus.Busy !== 1'b1) busy_bad++;
    check({name, "_done_cycle"}, 64'(k), 64'd34);
    check({name, "_busy_during"}, 64'(busy_bad), 64'd0);
    @(negedge clk);
    check({name, "_busy_after"}, 64'(bus.Busy), 64'd0);
  endtask

  // Main stimulus
  initial begin
    checks    = 0;
    errors    = 0;
    reset     = 1'b1;
    bus.start = 1'b0;
    bus.MulOp = 3'b000;
    bus.SrcA  = '0;
    bus.SrcB  = '0;
    repeat (2) @(negedge clk);
    check("reset_outputs", {29'd0, bus.Busy, bus.Done, bus.MulFlags, bus.ResultLo},
          64'd0);
    check("reset_hi", 64'(bus.ResultHi), 64'd0);
    reset = 1'b0;

    // Directed vectors with hand-computed products
    run_op("umull_max", OP_UMULL, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'h0000_0001, 2'b10);
    run_op("smull_m2x3", OP_SMULL, 32'hFFFF_FFFE, 32'd3, 32'hFFFF_FFFF, 32'hFFFF_FFFA, 2'b10);
    run_op("smull_min", OP_SMULL, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 32'h0000_0000, 2'b00);
    run_op("mul_wrap", OP_MUL, 32'h0001_0000, 32'h0001_0000, 32'h0000_0001, 32'h0000_0000, 2'b01);
    run_op("mul_neg_lo", OP_MUL, 32'd3, 32'hFFFF_FFFF, 32'h0000_0002, 32'hFFFF_FFFD, 2'b10);
    run_op("smull_zero", OP_SMULL, 32'd0, 32'hFFFF_FFFB, 32'h0000_0000, 32'h0000_0000, 2'b01);
    run_op("smull_7xm1", OP_SMULL, 32'd7, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFF9, 2'b10);

    // Starts while busy, during DONE, and with an invalid op are all ignored
    exp_q.push_back({32'd0, 32'd42, 2'b00});
    issue(OP_UMULL, 32'd7, 32'd6);          // now in cycle 1
    repeat (4) @(negedge clk);              // cycle 5
    bus.start = 1'b1; bus.MulOp = OP_SMULL; bus.SrcA = 32'h1234_5678; bus.SrcB = 32'h8765_4321;
    @(negedge clk);                         // cycle 6
    bus.start = 1'b0;
    repeat (28) @(negedge clk);             // cycle 34
    check("ignore_done_cycle", 64'(bus.Done), 64'd1);
    bus.start = 1'b1; bus.SrcA = 32'd9; bus.SrcB = 32'd9;
    @(negedge clk);                         // cycle 35
    check("ignore_start_in_done", 64'(bus.Busy), 64'd0);
    bus.MulOp = 3'b100;
    @(negedge clk);                         // cycle 36
    bus.start = 1'b0;
    check("invalid_op_busy", 64'(bus.Busy), 64'd0);
    check("invalid_op_hold_lo", 64'(bus.ResultLo), 64'd42);
    repeat (3) @(negedge clk);
    check("invalid_op_idle", 64'(bus.Busy), 64'd0);

    // Asynchronous reset in the middle of an operation
    issue(OP_UMULL, 32'hDEAD_BEEF, 32'h0000_0100);  // cycle 1
    repeat (9) @(negedge clk);                       // cycle 10
    check("pre_reset_busy", 64'(bus.Busy), 64'd1);
    reset = 1'b1;
    #1;
    check("async_reset_ctl", {62'd0, bus.Busy, bus.Done}, 64'd0);
    check("async_reset_res", {bus.ResultHi, bus.ResultLo}, 64'd0);
    check("async_reset_flags", 64'(bus.MulFlags), 64'd0);
    @(negedge clk);
    reset = 1'b0;
    repeat (40) @(negedge clk);
    check("no_done_after_abort", 64'(exp_q.size()), 64'd0);
    run_op("umull_5x5", OP_UMULL, 32'd5, 32'd5, 32'd0, 32'd25, 2'b00);

    repeat (3) @(negedge clk);
    check("scoreboard_drained", 64'(exp_q.size()), 64'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  // Global time bound
  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish, required completion");
    $fatal(1, "timeout");
  end
endmodule

// File: doc/mul_sequencer.md
# mul_sequencer

Multi-cycle integer multiply engine for the multicycle core, executing the MUL, UMULL and SMULL operations selected by the ALU decoder's ALUControl codes 3'b101/3'b110/3'b111. It accepts a one-cycle start from the main FSM and runs a radix-2 shift-add datapath, one multiplier bit per cycle. Busy holds the main FSM in its execute state until a one-cycle Done pulse presents registered 64-bit results and N/Z flags for writeback.

## Interface
- WIDTH, 32, operand width; products are 2*WIDTH bits.
- clk  in  1  core clock; all state changes on rising edge.
- reset  in  1  asynchronous, active-high; forces the reset state below immediately.
- start  in  1  request; sampled only in IDLE.
- MulOp  in  3  3'b101 MUL, 3'b110 UMULL, 3'b111 SMULL; any other value makes start ignored.
- SrcA  in  WIDTH  multiplicand (Rn); sampled with an accepted start.
- SrcB  in  WIDTH  multiplier (Rm); sampled with an accepted start.
- Busy  out  1  high whenever state != IDLE.
- Done  out  1  high exactly one cycle (DONE state).
- ResultLo  out  WIDTH  low product word.
- ResultHi  out  WIDTH  high product word.
- MulFlags  out  2  {N, Z}.

## Operation
- States: IDLE, RUN, SIGN, DONE.
- IDLE: start=1 and valid MulOp -> latch op, operands, next state RUN with bit counter = 0. Otherwise stay in IDLE.
- RUN operand prep, at accept:
  - MUL/UMULL: multiplicand M = SrcA, multiplier Q = SrcB, neg = 0.
  - SMULL: M = |SrcA|, Q = |SrcB| as unsigned WIDTH-bit magnitudes (-2^(WIDTH-1) maps to 2^(WIDTH-1)); neg = SrcA[MSB]^SrcB[MSB].
- RUN: product register P (2*WIDTH), initialised {0, Q}.
  - Each cycle: if P[0], add M to P[2W-1:W] with a WIDTH+1-bit sum including carry-out.
  - Then shift {carry, P} right one place.
  - Counter increments; after WIDTH cycles, next state SIGN.
- SIGN: if neg, P <= -P (two's complement, 2*WIDTH bits); otherwise P unchanged.
- DONE entry, i.e. the SIGN -> DONE edge:
  - ResultLo <= P[W-1:0].
  - ResultHi <= P[2W-1:W].
  - MUL: ResultHi is the upper unsigned product word. N = ResultLo MSB. Z = (ResultLo == 0).
  - UMULL/SMULL: N = ResultHi MSB. Z = (full 64-bit product == 0).
- DONE: Done=1 for one cycle; next state IDLE unconditionally. A start during DONE is ignored.
- Results and flags update only on DONE entry. They hold their values until the next DONE entry.
- start while Busy: ignored. The in-flight operation and operands are unaffected.
- Invalid MulOp with start: no state change, Busy stays 0.
- Reset (any time, including mid-RUN): state IDLE, counter 0, P 0, ResultLo 0, ResultHi 0, MulFlags 2'b00, Busy 0, Done 0. The aborted operation produces no Done.

## Timing
- Cycle 0: start accepted.
- Cycles 1..WIDTH: RUN.
- Cycle WIDTH+1: SIGN.
- Cycle WIDTH+2: DONE. For WIDTH=32, Done is high in cycle 34.
- Busy is high in cycles 1..WIDTH+2; Busy is 0 in cycle 0 (Mealy-free: registered outputs only).
- ResultLo/ResultHi/MulFlags are valid from the Done cycle onward.
- Earliest back-to-back start: cycle WIDTH+3. Throughput is one multiply per WIDTH+3 cycles.
- No combinational path from inputs to outputs.

## Test plan
- UMULL SrcA=0xFFFFFFFF, SrcB=0xFFFFFFFF, start at cycle 0 -> Done only in cycle 34; Hi=0xFFFFFFFE, Lo=0x00000001, N=1, Z=0; Busy high cycles 1..34.
- SMULL SrcA=0xFFFFFFFE (-2), SrcB=3 -> Hi=0xFFFFFFFF, Lo=0xFFFFFFFA, N=1, Z=0.
- SMULL SrcA=0x80000000, SrcB=0x80000000 -> Hi=0x40000000, Lo=0x00000000, N=0, Z=0.
- MUL SrcA=0x00010000, SrcB=0x00010000 -> Lo=0, Hi=1, Z=1, N=0.
- UMULL 7*6 started; start pulses with MulOp=3'b111 and new operands at cycles 5 and 34; MulOp=3'b100 start in IDLE -> single Done, Lo=42, Hi=0; the 3'b100 request leaves Busy=0.
- Reset asserted mid-cycle at cycle 10 of a UMULL -> Busy, Done, results and flags 0 before the next edge. No Done follows. A subsequent UMULL 5*5 returns Lo=25 at its cycle 34.
